// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Imported by fetch_fifo and fetch_unit.
package fetch_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One queued instruction together with the address it was fetched from.
  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue between imem responses and decode. The pointers carry an
// extra wrap bit so that full and empty can be told apart.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = CW - 1;

  fetch_entry_t  mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // NOTE: sequential state is written with non-blocking assignments so that
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; the pointers
  // alone decide which entries are valid, so clearing the data buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end: PC generation, credit-limited imem
// requests, in-order responses into a queue, and redirect with stale-drop.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter  int              XLEN     = DEFAULT_XLEN,
  parameter  logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter  int              DEPTH    = 4,
  localparam int              CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            misalign
);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redirect_target;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_next;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   occupancy;
  logic [CW:0]     committed;
  logic            fifo_full;
  logic            fifo_empty;
  logic            req_fire;
  logic            enqueue;
  logic            dequeue;
  fetch_entry_t    head;
  fetch_entry_t    rsp_entry;

  // Every request already holds a queue slot, so a response can never overflow.
  assign committed      = {1'b0, occupancy} + {1'b0, inflight};
  assign imem_req_valid = rst && !fifo_full && (committed < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inflight_next   = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  assign enqueue   = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign rsp_entry = '{pc: resp_pc, inst: imem_rsp_data};

  assign inst_valid = !fifo_empty && !redirect_valid;
  assign dequeue    = inst_valid && inst_ready;
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (enqueue),
    .push_data (rsp_entry),
    .pop       (dequeue),
    .flush     (redirect_valid),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      misalign <= 1'b0;
    end else begin
      inflight <= inflight_next;
      if (redirect_valid) begin
        // Everything still outstanding after this edge belongs to the old path.
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        drop_cnt <= inflight_next;
        if (redirect_pc[1:0] != 2'b00) misalign <= 1'b1;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (enqueue)  resp_pc  <= resp_pc + XLEN'(4);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

endmodule
